ex_muldiv_unit: RTL and testbench
=================================

# ex_muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, fed by the decode→execute pipeline register. It takes the E-stage operands and funct3 for M-extension instructions and computes the result over a fixed 32-iteration sequence. While it runs, it asserts a stall toward the hazard unit, and it presents a one-cycle `done` with the 32-bit result for the E→M pipeline register.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; only 32 is supported.
- `ITER`, 32: iterations per operation; equals `XLEN`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous abort; driven from the same source as the D/E `clr`.
- `MulDivE`  in  1  the instruction in E is an M-extension op (start request).
- `funct3E`  in  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcAE`  in  32  rs1 value, already forwarded.
- `SrcBE`  in  32  rs2 value, already forwarded.
- `StallMD`  out  1  combinational; high means the F, D and E stages must hold.
- `DoneMD`  out  1  registered one-cycle pulse; `ResultMD` is valid.
- `ResultMD`  out  32  registered result; holds its value until the next completion.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If `MulDivE` is high, latch the operation, operand magnitudes and sign flags; clear the counter; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY: perform one iteration per cycle.
  - Multiply: radix-2 shift-add on unsigned magnitudes into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit quotient and 32-bit remainder.
  - The counter counts 0..31. At count 31, register the sign-corrected result into `ResultMD` and go to DONE.
- DONE: `DoneMD`=1 for exactly this cycle, then go to IDLE.
  - `MulDivE` is ignored in DONE; it is still the same instruction, which leaves E at the end of this cycle.
- `StallMD` = (IDLE & `MulDivE` & ~`flush`) | BUSY. It is low in DONE.
- A new `MulDivE` while BUSY is ignored; that cannot occur legally because E is stalled.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - MUL: low 32 bits, identical for any signedness.
  - DIV, REM: both operands signed.
- Sign correction:
  - Product is negated (64-bit two's complement) when the operand signs differ.
  - Quotient is negated when the dividend and divisor signs differ and the divisor is non-zero.
  - Remainder takes the sign of the dividend.
- Result selection: MUL → product[31:0]; MULH, MULHSU, MULHU → product[63:32]; DIV, DIVU → quotient; REM, REMU → remainder.
- Boundary cases (the latency stays fixed at 32 iterations in all of them):
  - Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- `flush` or `reset` in any state: next state is IDLE and no `DoneMD` is produced. `reset` also clears `ResultMD` and the counter; `flush` leaves `ResultMD` unchanged.

## Timing
- Reset values: state IDLE, `StallMD`=0 (when `MulDivE`=0), `DoneMD`=0, `ResultMD`=0, counter=0.
- Latency with `MulDivE` first high in cycle C:
  - `StallMD` is high in cycles C..C+32 (33 cycles).
  - `DoneMD` is high and `ResultMD` is valid in cycle C+33.
  - The pipeline advances at the end of cycle C+33.
- Back-to-back M ops: the next instruction reaches E in C+34, is seen in IDLE, and starts immediately. There is no extra bubble beyond the DONE cycle.
- If `flush` and `MulDivE` are both high in IDLE, `flush` wins and the unit does not start.

## Structure
- A shared package/include holds:
  - the funct3 M-op codes (`F3_MUL` … `F3_REMU`);
  - the FSM state encodings;
  - `XLEN`.
- A single module is sufficient. The datapath (accumulator, remainder/quotient shift registers, negation logic) fits comfortably in roughly 200–300 lines; no sub-module is needed.
- Operands are captured in IDLE, so forwarding changes during BUSY have no effect.

## Test plan
- MUL: 7 × 0xFFFFFFFD → `ResultMD`=0xFFFFFFEB; `DoneMD` in cycle C+33; `StallMD` high for exactly 33 cycles.
- MULH: 0x80000000 × 0x80000000 → 0x40000000. MULHU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU: 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV: 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM: same operands → 0xFFFFFFFF. DIVU: 100 / 7 → 14. REMU: same operands → 2.
- Divide by zero: DIV 5/0 → 0xFFFFFFFF; REMU 5/0 → 5. Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM same operands → 0. Each completes with the full 33-cycle stall.
- `flush` in cycle C+10 of a DIV:
  - `StallMD`=0 from C+11;
  - no `DoneMD` pulse;
  - `ResultMD` keeps its prior value;
  - a following MUL starts cleanly.
- `reset` mid-BUSY: all outputs return to their reset values in the next cycle. Also run two back-to-back MULs: two `DoneMD` pulses exactly 34 cycles apart.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 operation codes, FSM state encodings and datapath width.
package ex_muldiv_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the execute stage: 32 iterations per op,
// stalls F/D/E while running, presents a one-cycle DoneMD with the registered result.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | waiting; MulDivE & ~flush captures operands and starts
//   ST_BUSY | one shift-add / shift-subtract iteration per cycle (0..31)
//   ST_DONE | DoneMD high, ResultMD valid; instruction leaves E
module ex_muldiv_unit #(
  parameter int XLEN = ex_muldiv_unit_pkg::XLEN,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            MulDivE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] SrcAE,
  input  logic [XLEN-1:0] SrcBE,
  output logic            StallMD,
  output logic            DoneMD,
  output logic [XLEN-1:0] ResultMD
);
  import ex_muldiv_unit_pkg::*;

  localparam int CW = $clog2(ITER);

  md_state_e         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              done_q, done_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              neg_cap;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_trial;
  logic [2*XLEN-1:0] mul_step, div_step, step, prod_fix;
  logic [XLEN-1:0]   res_sel;

  // Operand signedness and magnitudes, evaluated on the E-stage inputs at capture.
  always_comb begin
    a_signed = (funct3E == F3_MULH) || (funct3E == F3_MULHSU) ||
               (funct3E == F3_DIV)  || (funct3E == F3_REM);
    b_signed = (funct3E == F3_MULH) || (funct3E == F3_DIV) || (funct3E == F3_REM);
    a_neg    = a_signed & SrcAE[XLEN-1];
    b_neg    = b_signed & SrcBE[XLEN-1];
    a_mag    = a_neg ? -SrcAE : SrcAE;
    b_mag    = b_neg ? -SrcBE : SrcBE;
    case (funct3E)
      F3_DIV, F3_DIVU: neg_cap = (a_neg ^ b_neg) & (|SrcBE);
      F3_REM, F3_REMU: neg_cap = a_neg;
      default:         neg_cap = a_neg ^ b_neg;
    endcase
  end

  // Multiply keeps {product_hi, multiplier} in acc; divide keeps {remainder, quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    mul_step  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    div_trial = {1'b0, acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {2'b00, mcand_q};
    div_step  = div_trial[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                  : {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    step      = op_q[2] ? div_step : mul_step;
    prod_fix  = neg_q ? -step : step;
    case (op_q)
      F3_MUL:                      res_sel = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res_sel = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             res_sel = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
      default:                     res_sel = neg_q ? -step[2*XLEN-1:XLEN]
                                                   : step[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    res_d   = res_q;
    done_d  = 1'b0;
    StallMD = 1'b0;
    case (state_q)
      ST_IDLE: begin
        StallMD = MulDivE & ~flush;
        if (MulDivE) begin
          op_d    = funct3E;
          neg_d   = neg_cap;
          mcand_d = funct3E[2] ? b_mag : a_mag;
          acc_d   = {{XLEN{1'b0}}, (funct3E[2] ? a_mag : b_mag)};
          cnt_d   = '0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        StallMD = 1'b1;
        acc_d   = step;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) begin
          res_d   = res_sel;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // An abort at any point drops the op without touching the visible result.
    if (flush) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign DoneMD   = done_q;
  assign ResultMD = res_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed RV32M cases, randomized ops against
// an arithmetic reference model, flush/reset aborts and back-to-back timing.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, flush, MulDivE;
  logic [2:0]  funct3E;
  logic [31:0] SrcAE, SrcBE;
  logic        StallMD, DoneMD;
  logic [31:0] ResultMD;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [31:0] exp_last;

  logic [2:0]  d_f [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
  logic [31:0] d_a [12] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                            32'hFFFFFFF9, 32'd100, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
  logic [31:0] d_b [12] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                            32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] d_e [12] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                            32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ex_muldiv_unit dut (
    .clk(clk), .reset(reset), .flush(flush), .MulDivE(MulDivE), .funct3E(funct3E),
    .SrcAE(SrcAE), .SrcBE(SrcBE), .StallMD(StallMD), .DoneMD(DoneMD), .ResultMD(ResultMD)
  );

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, ua, ub, q;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin if (b == 0) return 32'hFFFFFFFF; q = sa / sb; return q[31:0]; end
      3'd5: begin if (b == 0) return 32'hFFFFFFFF; q = ua / ub; return q[31:0]; end
      3'd6: begin if (b == 0) return a; q = sa % sb; return q[31:0]; end
      default: begin if (b == 0) return a; q = ua % ub; return q[31:0]; end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  // Holds MulDivE high (as the stalled E stage does) and scrambles the forwarded
  // operands after issue; returns at the DONE cycle without releasing MulDivE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int dk, output int stalls,
                        output int dcyc);
    int start;
    res = '0; dk = -1; stalls = 0; dcyc = -1;
    @(negedge clk);
    funct3E = f; SrcAE = a; SrcBE = b; MulDivE = 1'b1; flush = 1'b0;
    start = cyc;
    for (int k = 0; k < 48; k++) begin
      #1;
      if (StallMD) stalls++;
      if (DoneMD) begin
        dk = cyc - start; dcyc = cyc; res = ResultMD;
        break;
      end
      @(negedge clk);
      funct3E = 3'($urandom); SrcAE = $urandom; SrcBE = $urandom;
    end
  endtask

  task automatic release_op();
    @(negedge clk);
    MulDivE = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; MulDivE = 1'b0; funct3E = 3'd0; SrcAE = '0; SrcBE = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++; if (StallMD !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", StallMD); end
    n_checks++; if (DoneMD !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", DoneMD); end
    n_checks++; if (ResultMD !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", ResultMD); end
    exp_last = 32'h0;
  endtask

  task automatic test_directed();
    logic [31:0] res;
    int dk, st, dc;
    for (int i = 0; i < 12; i++) begin
      run_op(d_f[i], d_a[i], d_b[i], res, dk, st, dc);
      release_op();
      n_checks++;
      if (res !== d_e[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d] f3=%0d a=%h b=%h: got %h expected %h", i, d_f[i], d_a[i], d_b[i], res, d_e[i]);
      end
      n_checks++; if (dk !== 33) begin n_fail++; $display("FAIL directed_latency[%0d]: got %0d expected 33", i, dk); end
      n_checks++; if (st !== 33) begin n_fail++; $display("FAIL directed_stall_cycles[%0d]: got %0d expected 33", i, st); end
      exp_last = d_e[i];
    end
  endtask

  task automatic test_random();
    logic [31:0] a, b, exp, res;
    logic [2:0]  f;
    int dk, st, dc;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7)); a = pick(); b = pick();
      exp = ref_model(f, a, b);
      run_op(f, a, b, res, dk, st, dc);
      release_op();
      n_checks++;
      if (res !== exp || dk !== 33) begin
        n_fail++;
        $display("FAIL random[%0d] f3=%0d a=%h b=%h: got %h at %0d expected %h at 33", i, f, a, b, res, dk, exp);
      end
      exp_last = exp;
    end
  endtask

  task automatic test_flush();
    logic [31:0] a, b, res, exp;
    int bad_stall, n_done, dk, st, dc;
    @(negedge clk);
    funct3E = 3'd4; SrcAE = $urandom; SrcBE = $urandom | 32'h1; MulDivE = 1'b1; flush = 1'b1;
    #1;
    n_checks++; if (StallMD !== 1'b0) begin n_fail++; $display("FAIL flush_wins_idle: got %b expected 0", StallMD); end
    @(negedge clk);
    MulDivE = 1'b0; flush = 1'b0;
    #1;
    n_checks++; if (StallMD !== 1'b0) begin n_fail++; $display("FAIL flush_no_start: got %b expected 0", StallMD); end
    @(negedge clk);
    funct3E = 3'd4; SrcAE = $urandom; SrcBE = $urandom | 32'h1; MulDivE = 1'b1;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; MulDivE = 1'b0;
    bad_stall = 0; n_done = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (StallMD) bad_stall++;
      if (DoneMD) n_done++;
      @(negedge clk);
    end
    n_checks++; if (bad_stall !== 0) begin n_fail++; $display("FAIL flush_stall_cycles: got %0d expected 0", bad_stall); end
    n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL flush_done_pulses: got %0d expected 0", n_done); end
    n_checks++; if (ResultMD !== exp_last) begin n_fail++; $display("FAIL flush_result_kept: got %h expected %h", ResultMD, exp_last); end
    a = $urandom; b = $urandom;
    exp = ref_model(3'd0, a, b);
    run_op(3'd0, a, b, res, dk, st, dc);
    release_op();
    n_checks++;
    if (res !== exp || dk !== 33 || st !== 33) begin
      n_fail++;
      $display("FAIL flush_then_mul: got %h lat %0d stall %0d expected %h lat 33 stall 33", res, dk, st, exp);
    end
    exp_last = exp;
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int dk, st, dc, bad;
    run_op(3'd0, 32'd3, 32'd5, res, dk, st, dc);
    release_op();
    n_checks++; if (res !== 32'd15) begin n_fail++; $display("FAIL pre_reset_mul: got %h expected 0000000f", res); end
    @(negedge clk);
    funct3E = 3'd5; SrcAE = $urandom; SrcBE = $urandom; MulDivE = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1; MulDivE = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (StallMD !== 1'b0 || DoneMD !== 1'b0 || ResultMD !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got stall %b done %b result %h expected 0 0 00000000", StallMD, DoneMD, ResultMD);
    end
    reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); #1;
      if (StallMD || DoneMD) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", bad); end
    exp_last = 32'h0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, r1, r2, e1, e2;
    int dk1, st1, dc1, dk2, st2, dc2;
    a1 = $urandom; b1 = $urandom; a2 = pick(); b2 = pick();
    e1 = ref_model(3'd0, a1, b1);
    e2 = ref_model(3'd0, a2, b2);
    run_op(3'd0, a1, b1, r1, dk1, st1, dc1);
    run_op(3'd0, a2, b2, r2, dk2, st2, dc2);
    release_op();
    n_checks++; if (r1 !== e1) begin n_fail++; $display("FAIL b2b_result1: got %h expected %h", r1, e1); end
    n_checks++; if (r2 !== e2) begin n_fail++; $display("FAIL b2b_result2: got %h expected %h", r2, e2); end
    n_checks++;
    if (dc1 < 0 || dc2 - dc1 !== 34) begin
      n_fail++;
      $display("FAIL b2b_done_spacing: got %0d expected 34", dc2 - dc1);
    end
    n_checks++; if (st2 !== 33) begin n_fail++; $display("FAIL b2b_stall2: got %0d expected 33", st2); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
